vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Master raster timing source for the VGA display path. Free-running
//  horizontal/vertical counters produce the sync, blanking and line-reset
//  strobes consumed by the sprite/paddle/ball video generators and the VGA pins.
//  Default timing is 640x480@60 Hz on a 25.175 MHz (nominal 25 MHz) pixel clock.
// PARAMETERS
//  p_H_VISIBLE  640  visible pixels per line
//  p_H_FRONT    16   horizontal front porch, pixels
//  p_H_SYNC     96   horizontal sync width, pixels
//  p_H_BACK     48   horizontal back porch, pixels
//  p_V_VISIBLE  480  visible lines per frame
//  p_V_FRONT    10   vertical front porch, lines
//  p_V_SYNC     2    vertical sync width, lines
//  p_V_BACK     33   vertical back porch, lines
//  p_SYNC_POL   0    active sync level (0 = active-low, VGA standard)
// PORTS
//  i_Clk         in   1   pixel clock
//  i_Rst_n       in   1   asynchronous reset, active low
//  o_HCount      out  10  current pixel column, 0..H_TOTAL-1
//  o_VCount      out  10  current line, 0..V_TOTAL-1
//  o_HBlank      out  1   high while o_HCount >= p_H_VISIBLE
//  o_VBlank      out  1   high while o_VCount >= p_V_VISIBLE
//  o_HSync       out  1   horizontal sync, level per p_SYNC_POL
//  o_VSync       out  1   vertical sync, level per p_SYNC_POL
//  o_HReset      out  1   one-cycle strobe on last pixel of every line
//  o_FrameEnd    out  1   one-cycle strobe on last pixel of every frame
// BEHAVIOUR
//  - One clock (i_Clk), asynchronous active-low reset i_Rst_n; all outputs registered.
//  - H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
//  - Reset: HCount=0, VCount=0, HBlank=0, VBlank=0, HSync=VSync=~p_SYNC_POL,
//    HReset=0, FrameEnd=0. First clock after release continues from pixel (0,0).
//  - HCount increments every clock; at H_TOTAL-1 wraps to 0 and VCount advances.
//    VCount wraps to 0 after V_TOTAL-1. No enable, no stall.
//  - All strobes/levels are decoded for the same (HCount,VCount) shown on the
//    count outputs in that cycle: zero skew between counts and flags.
//  - HSync active for HCount in [H_VIS+H_FRONT, H_VIS+H_FRONT+H_SYNC-1] (656..751).
//  - VSync active for whole lines VCount in [V_VIS+V_FRONT, +V_SYNC-1] (490..491);
//    VSync edges coincide with HCount=0.
//  - HReset high when HCount==H_TOTAL-1, every line incl. blanked lines; o_VBlank
//    in that cycle refers to the line just ending. Consequence, relied on by
//    video generators: exactly p_V_VISIBLE HReset pulses with VBlank=0 per frame,
//    exactly p_H_VISIBLE cycles with HBlank=0 per line.
//  - FrameEnd high when HCount==H_TOTAL-1 and VCount==V_TOTAL-1 (also an HReset).
//  - Implementation: next-state counters with registered compare decodes of the
//    next values; no combinational output paths.
//  - Reset mid-frame: outputs return immediately (async) to reset values; no
//    partial strobes generated on reset assertion or release.
// TESTING
//  1 Release reset, run 420000 clocks -> exactly one FrameEnd, on clock 419999;
//    counts back to (0,0) on clock 420000.
//  2 Line 0 -> HBlank 0 for HCount 0..639, 1 for 640..799; HReset only at 799.
//  3 Line 0 -> HSync low exactly at HCount 656..751 (96 clocks), high elsewhere.
//  4 Full frame -> VBlank low for lines 0..479; VSync low lines 490..491 (1600
//    clocks); count of HReset with VBlank=0 equals 480; total HReset = 525.
//  5 Assert i_Rst_n low at (300,200) between clock edges -> outputs at reset
//    values before next edge; after release sequence restarts from (0,0).
//  6 Override p_SYNC_POL=1, p_H_VISIBLE=8 small params -> sync polarity inverted,
//    line/frame periods equal parameter sums, flag windows shift accordingly.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the video generators and the VGA pins.
// There is no handshake: every signal is valid on every pixel clock and cannot be stalled.
interface vga_timing_gen_if;
  logic [9:0] o_HCount;
  logic [9:0] o_VCount;
  logic       o_HBlank;
  logic       o_VBlank;
  logic       o_HSync;
  logic       o_VSync;
  logic       o_HReset;
  logic       o_FrameEnd;

  modport master (
    output o_HCount, o_VCount, o_HBlank, o_VBlank,
           o_HSync, o_VSync, o_HReset, o_FrameEnd
  );

  modport slave (
    input  o_HCount, o_VCount, o_HBlank, o_VBlank,
           o_HSync, o_VSync, o_HReset, o_FrameEnd
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counters with registered sync, blank and strobe flags.
// Flags are decoded from the next-state counts, so they line up with the counts on the same cycle.
module vga_timing_gen #(
  parameter int p_H_VISIBLE = 640,
  parameter int p_H_FRONT   = 16,
  parameter int p_H_SYNC    = 96,
  parameter int p_H_BACK    = 48,
  parameter int p_V_VISIBLE = 480,
  parameter int p_V_FRONT   = 10,
  parameter int p_V_SYNC    = 2,
  parameter int p_V_BACK    = 33,
  parameter int p_SYNC_POL  = 0
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  vga_timing_gen_if.master timing_o
);

  localparam int H_TOTAL = p_H_VISIBLE + p_H_FRONT + p_H_SYNC + p_H_BACK;
  localparam int V_TOTAL = p_V_VISIBLE + p_V_FRONT + p_V_SYNC + p_V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(p_H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(p_V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(p_H_VISIBLE + p_H_FRONT);
  localparam logic [9:0] HS_END     = 10'(p_H_VISIBLE + p_H_FRONT + p_H_SYNC - 1);
  localparam logic [9:0] VS_START   = 10'(p_V_VISIBLE + p_V_FRONT);
  localparam logic [9:0] VS_END     = 10'(p_V_VISIBLE + p_V_FRONT + p_V_SYNC - 1);
  localparam logic       SYNC_ACT   = 1'(p_SYNC_POL);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       hblank_q, hblank_d;
  logic       vblank_q, vblank_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       hreset_q, hreset_d;
  logic       frame_end_q, frame_end_d;

  always_comb begin
    hcount_d    = hcount_q;
    vcount_d    = vcount_q;
    hblank_d    = 1'b0;
    vblank_d    = 1'b0;
    hsync_d     = ~SYNC_ACT;
    vsync_d     = ~SYNC_ACT;
    hreset_d    = 1'b0;
    frame_end_d = 1'b0;

    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
    end else begin
      hcount_d = hcount_q + 10'd1;
    end

    // Decode the values the counters are about to take so flags and counts register together.
    hblank_d    = (hcount_d >= H_VIS);
    vblank_d    = (vcount_d >= V_VIS);
    hsync_d     = (hcount_d >= HS_START && hcount_d <= HS_END) ? SYNC_ACT : ~SYNC_ACT;
    vsync_d     = (vcount_d >= VS_START && vcount_d <= VS_END) ? SYNC_ACT : ~SYNC_ACT;
    hreset_d    = (hcount_d == H_LAST);
    frame_end_d = (hcount_d == H_LAST) && (vcount_d == V_LAST);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      hblank_q    <= 1'b0;
      vblank_q    <= 1'b0;
      hsync_q     <= ~SYNC_ACT;
      vsync_q     <= ~SYNC_ACT;
      hreset_q    <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      hreset_q    <= hreset_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign timing_o.o_HCount   = hcount_q;
  assign timing_o.o_VCount   = vcount_q;
  assign timing_o.o_HBlank   = hblank_q;
  assign timing_o.o_VBlank   = vblank_q;
  assign timing_o.o_HSync    = hsync_q;
  assign timing_o.o_VSync    = vsync_q;
  assign timing_o.o_HReset   = hreset_q;
  assign timing_o.o_FrameEnd = frame_end_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny inverted-polarity instance
// share one clock and reset; expected rasters are queued per cycle and popped by a monitor.
module tb_vga_timing_gen;

  localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VV = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
  localparam int A_HT = A_HV + A_HF + A_HS + A_HB;
  localparam int A_VT = A_VV + A_VF + A_VS + A_VB;

  localparam int B_HV = 8, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VV = 4, B_VF = 1, B_VS = 2, B_VB = 1;
  localparam int B_HT = B_HV + B_HF + B_HS + B_HB;
  localparam int B_VT = B_VV + B_VF + B_VS + B_VB;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if a_if ();
  vga_timing_gen_if b_if ();

  vga_timing_gen dut_a (
    .i_Clk    (clk),
    .i_Rst_n  (rst_n),
    .timing_o (a_if)
  );

  vga_timing_gen #(
    .p_H_VISIBLE (B_HV), .p_H_FRONT (B_HF), .p_H_SYNC (B_HS), .p_H_BACK (B_HB),
    .p_V_VISIBLE (B_VV), .p_V_FRONT (B_VF), .p_V_SYNC (B_VS), .p_V_BACK (B_VB),
    .p_SYNC_POL  (1)
  ) dut_b (
    .i_Clk    (clk),
    .i_Rst_n  (rst_n),
    .timing_o (b_if)
  );

  // scoreboard state
  logic [25:0] exp_a_q[$];
  logic [25:0] exp_b_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit tally_en    = 1'b0;
  int ha = 0, va = 0, hb = 0, vb = 0;

  // hand-countable tallies over line 0 of A and frame 0 of B
  int a_hvis = 0, a_hs = 0, a_hr = 0, a_hr_at = -1;
  int b_fe = 0, b_fe_at = -1, b_hr = 0, b_hr_vis = 0, b_vs = 0, b_hvis = 0;

  function automatic logic [25:0] exp_vec(int h, int v, int hv, int hf, int hs, int hbk,
                                          int vv, int vf, int vs, int vbk, bit pol);
    int  ht, vt;
    logic hbl, vbl, hsy, vsy, hr, fe;
    ht  = hv + hf + hs + hbk;
    vt  = vv + vf + vs + vbk;
    hbl = (h >= hv);
    vbl = (v >= vv);
    hsy = (h >= hv + hf && h < hv + hf + hs) ? pol : ~pol;
    vsy = (v >= vv + vf && v < vv + vf + vs) ? pol : ~pol;
    hr  = (h == ht - 1);
    fe  = hr && (v == vt - 1);
    return {10'(h), 10'(v), hbl, vbl, hsy, vsy, hr, fe};
  endfunction

  task automatic check_vec(string name, logic [25:0] got, logic [25:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got h=%0d v=%0d flags=%b exp h=%0d v=%0d flags=%b",
               name, cyc, got[25:16], got[15:6], got[5:0], exp[25:16], exp[15:6], exp[5:0]);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic push_expected();
    exp_a_q.push_back(exp_vec(ha, va, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, 1'b0));
    exp_b_q.push_back(exp_vec(hb, vb, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, 1'b1));
  endtask

  task automatic advance_models();
    if (ha == A_HT - 1) begin
      ha = 0;
      va = (va == A_VT - 1) ? 0 : va + 1;
    end else ha++;
    if (hb == B_HT - 1) begin
      hb = 0;
      vb = (vb == B_VT - 1) ? 0 : vb + 1;
    end else hb++;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst_n) advance_models();
    #1 push_expected();
  endtask

  // monitor: one output vector per pixel clock, sampled on the falling edge
  always @(negedge clk) begin
    logic [25:0] e;
    if (exp_a_q.size() > 0) begin
      e = exp_a_q.pop_front();
      check_vec("sb_a", {a_if.o_HCount, a_if.o_VCount, a_if.o_HBlank, a_if.o_VBlank,
                         a_if.o_HSync, a_if.o_VSync, a_if.o_HReset, a_if.o_FrameEnd}, e);
    end
    if (exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front();
      check_vec("sb_b", {b_if.o_HCount, b_if.o_VCount, b_if.o_HBlank, b_if.o_VBlank,
                         b_if.o_HSync, b_if.o_VSync, b_if.o_HReset, b_if.o_FrameEnd}, e);
    end
    if (tally_en && cyc < A_HT) begin
      if (!a_if.o_HBlank) a_hvis++;
      if (!a_if.o_HSync)  a_hs++;
      if (a_if.o_HReset) begin a_hr++; a_hr_at = cyc; end
    end
    if (tally_en && cyc < B_HT * B_VT) begin
      if (b_if.o_FrameEnd) begin b_fe++; b_fe_at = cyc; end
      if (b_if.o_HReset) b_hr++;
      if (b_if.o_HReset && !b_if.o_VBlank) b_hr_vis++;
      if (b_if.o_VSync)  b_vs++;
      if (!b_if.o_HBlank) b_hvis++;
    end
  end

  initial begin
    push_expected();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc      = 0;
    tally_en = 1'b1;
    push_expected();

    repeat (1900) step();
    tally_en = 1'b0;

    // asynchronous reset between edges, mid-line for A and mid-frame for B
    @(posedge clk);
    cyc++;
    advance_models();
    #2 rst_n = 1'b0;
    ha = 0; va = 0; hb = 0; vb = 0;
    #1 push_expected();
    step();
    step();
    rst_n = 1'b1;
    repeat (600) step();

    @(negedge clk);
    #1;
    check_int("a_line0_hvisible", a_hvis, 640);
    check_int("a_line0_hsync_cycles", a_hs, 96);
    check_int("a_line0_hreset_count", a_hr, 1);
    check_int("a_line0_hreset_at", a_hr_at, 799);
    check_int("b_frame_end_count", b_fe, 1);
    check_int("b_frame_end_at", b_fe_at, 119);
    check_int("b_hreset_total", b_hr, 8);
    check_int("b_hreset_visible", b_hr_vis, 4);
    check_int("b_vsync_cycles", b_vs, 30);
    check_int("b_hvisible_cycles", b_hvis, 64);
    check_int("sb_a_drained", exp_a_q.size(), 0);
    check_int("sb_b_drained", exp_b_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
